// File: rtl/axi4_bram_responder.sv
// AXI4 slave over a register-array memory, with independent read and write FSMs.
// Read data follows AR by 1 cycle and BVALID follows the last W beat by 1 cycle; R/B outputs hold while the master stalls.
module axi4_bram_responder #(
  parameter int memWidth      = 8,
  parameter int memDepth      = 32,
  parameter int addressLength = 5
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [3:0]               ARID,
  input  logic [addressLength-1:0] ARADDR,
  input  logic [1:0]               ARBURST,
  input  logic [7:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [3:0]               RID,
  output logic [memWidth-1:0]      RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [3:0]               AWID,
  input  logic [addressLength-1:0] AWADDR,
  input  logic [1:0]               AWBURST,
  input  logic [7:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [3:0]               WID,
  input  logic [memWidth-1:0]      WDATA,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [3:0]               BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY
);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_DATA      = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;
  localparam logic       R_IDLE      = 1'b0;
  localparam logic       R_DATA      = 1'b1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [memWidth-1:0] mem [memDepth];

  logic [1:0]               w_state;
  logic [3:0]               w_id;
  logic [addressLength-1:0] w_addr;
  logic [7:0]               w_len;
  logic [7:0]               w_cnt;
  logic [1:0]               w_burst;
  logic                     w_err;
  logic                     w_beat;
  logic                     w_last;
  logic                     w_last_bad;
  logic                     mem_we;

  logic                     r_state;
  logic [addressLength-1:0] r_addr;
  logic [addressLength-1:0] r_next;
  logic [7:0]               r_len;
  logic [7:0]               r_cnt;
  logic [1:0]               r_burst;
  logic                     r_err;
  logic                     ar_err;

  logic unused_wid;
  assign unused_wid = ^WID;

  // INCR and WRAP both step by one word; the address width makes 31 -> 0 wrap for free.
  function automatic logic [addressLength-1:0] next_addr(input logic [1:0] burst,
                                                         input logic [addressLength-1:0] addr);
    next_addr = (burst == BURST_FIXED) ? addr : addr + 1'b1;
  endfunction

  assign w_beat     = (w_state == W_DATA) && WVALID && WREADY;
  assign w_last     = (w_cnt == w_len);
  assign w_last_bad = (WLAST != w_last);
  assign mem_we     = w_beat && !w_err;

  assign ar_err = (ARBURST == BURST_RSVD) || (ARSIZE != 3'd0);
  assign r_next = next_addr(r_burst, r_addr);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < memDepth; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[w_addr] <= WDATA;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID && AWREADY) begin
          w_id    <= AWID;
          w_addr  <= AWADDR;
          w_len   <= AWLEN;
          w_burst <= AWBURST;
          w_err   <= (AWBURST == BURST_RSVD) || (AWSIZE != 3'd0);
          w_cnt   <= '0;
          AWREADY <= 1'b0;
          WREADY  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (w_beat) begin
          // Beat count alone ends the burst; a misplaced WLAST only poisons the response.
          if (w_last) begin
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BID     <= w_id;
            BRESP   <= (w_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end else begin
            w_err  <= w_err | w_last_bad;
            w_addr <= next_addr(w_burst, w_addr);
            w_cnt  <= w_cnt + 8'd1;
          end
        end
        W_RESP: if (BVALID && BREADY) begin
          BVALID  <= 1'b0;
          AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
        default: begin
          AWREADY <= 1'b1;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RDATA   <= '0;
      RID     <= '0;
      RRESP   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (ARVALID && ARREADY) begin
        r_err   <= ar_err;
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_burst <= ARBURST;
        r_cnt   <= '0;
        ARREADY <= 1'b0;
        RVALID  <= 1'b1;
        RID     <= ARID;
        RDATA   <= ar_err ? '0 : mem[ARADDR];
        RRESP   <= ar_err ? RESP_SLVERR : RESP_OKAY;
        RLAST   <= (ARLEN == 8'd0);
        r_state <= R_DATA;
      end
    end else if (RVALID && RREADY) begin
      if (RLAST) begin
        RVALID  <= 1'b0;
        RLAST   <= 1'b0;
        ARREADY <= 1'b1;
        r_state <= R_IDLE;
      end else begin
        // Memory is sampled before any same-edge write lands, so reads see old data.
        r_addr <= r_next;
        r_cnt  <= r_cnt + 8'd1;
        RDATA  <= r_err ? '0 : mem[r_next];
        RLAST  <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: doc/axi4_bram_responder.md
AXI4_BRAM_RESPONDER -- requirements
Module: axi4_bram_responder

Interface
REQ-001 Parameter memWidth, default 8, data width and memory word width in bits.
REQ-002 Parameter memDepth, default 32, number of memory words.
REQ-003 Parameter addressLength, default 5, address width; SHALL equal log2(memDepth).
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 Read-address channel: ARID in 4, ARADDR in addressLength, ARBURST in 2, ARLEN in 8, ARSIZE in 3, ARVALID in 1, ARREADY out 1.
REQ-007 Read-data channel: RID out 4, RDATA out memWidth, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1.
REQ-008 Write-address channel: AWID in 4, AWADDR in addressLength, AWBURST in 2, AWLEN in 8, AWSIZE in 3, AWVALID in 1, AWREADY out 1.
REQ-009 Write-data channel: WID in 4 (ignored), WDATA in memWidth, WLAST in 1, WVALID in 1, WREADY out 1.
REQ-010 Write-response channel: BID out 4, BRESP out 2, BVALID out 1, BREADY in 1.

Function
REQ-011 Storage: memDepth x memWidth register array; read and write paths operate independently and concurrently.
REQ-012 Write FSM states: W_IDLE, W_DATA, W_RESP; all outputs registered.
REQ-013 W_IDLE: AWREADY=1; on AWVALID&AWREADY capture AWID, AWADDR, AWLEN, AWBURST, clear error flag and beat counter, go to W_DATA (AWREADY=0, WREADY=1 next cycle).
REQ-014 W_DATA: each WVALID&WREADY beat writes WDATA to mem[waddr] (unless error), advances address per burst rule, increments beat counter; beat counter==AWLEN on a beat -> W_RESP, WREADY=0 next cycle.
REQ-015 WLAST mismatch (WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN) SHALL set error flag; beat count alone terminates the burst.
REQ-016 W_RESP: BVALID=1, BID=captured AWID, BRESP=2'b10 if error else 2'b00; held stable until BREADY; on BVALID&BREADY -> W_IDLE, AWREADY=1 next cycle.
REQ-017 Read FSM states: R_IDLE, R_DATA; all outputs registered.
REQ-018 R_IDLE: ARREADY=1; on ARVALID&ARREADY capture ARID, ARLEN, ARBURST, go to R_DATA; RVALID=1, RDATA=mem[ARADDR], RID=ARID the next cycle.
REQ-019 R_DATA: RVALID, RDATA, RRESP, RLAST, RID held stable while RREADY=0; on RVALID&RREADY next beat presented the following cycle (1 beat/cycle throughput).
REQ-020 RLAST=1 exactly on beat index ARLEN; handshake of that beat -> R_IDLE, RVALID=0 and ARREADY=1 next cycle.
REQ-021 Burst addressing: FIXED (00) address constant; INCR (01) and WRAP (10) address+1 modulo memDepth (31 -> 0).
REQ-022 Error: burst 2'b11 or SIZE!=0 -> SLVERR (2'b10) on every read beat with RDATA=0, or on BRESP with no memory writes; beat count and handshakes unchanged.
REQ-023 Same-cycle write and read-beat load to same address: read SHALL return pre-write contents.
REQ-024 ARLEN/AWLEN=0 SHALL be a single-beat burst with RLAST=1 on that beat.

Reset
REQ-025 ARESET=1 immediately forces: W_IDLE, R_IDLE, AWREADY=1, ARREADY=1, WREADY=0, RVALID=0, RLAST=0, BVALID=0, RDATA=0, RID=0, BID=0, RRESP=0, BRESP=0, memory all zeros.
REQ-026 Reset mid-burst SHALL abort the burst without a response; writes completed before reset are cleared by the memory reset.
REQ-027 First address handshake possible on the first rising edge after ARESET deasserts.

Verification
REQ-028 INCR write AWADDR=3, AWLEN=3, data 0xA1..0xA4, WLAST on beat 3, BREADY=1 -> BVALID one cycle after last beat, BRESP=00, BID=AWID; mem[3..6]=A1..A4.
REQ-029 INCR read ARADDR=30, ARLEN=3 after writing 0x11..0x14 to 30,31,0,1 -> RDATA 11,12,13,14, RLAST only on 4th beat, RRESP=00.
REQ-030 Read with RREADY toggling 1,0,0,1 -> RDATA/RLAST unchanged through stall cycles; no beat lost or duplicated.
REQ-031 Write AWLEN=2 with WLAST on beat 1 -> three beats accepted, BRESP=10; AWBURST=11 write -> memory unchanged, BRESP=10.
REQ-032 FIXED read ARADDR=5, ARLEN=2 -> three beats of mem[5]; concurrent write to 5 on first read-load cycle -> first beat returns old value.
REQ-033 Assert ARESET during W_DATA beat 2 -> WREADY=0, AWREADY=1, BVALID=0 immediately; memory reads all zero afterwards.
